// File: rtl/pipe_ex_mem_elastic_if.sv
// EX -> MEM pipeline handshake bundle: EX-side beat with valid/ready and MEM-side beat with valid/ready.
// The stage uses the slave modport; the surrounding EX producer / MEM consumer use master.
interface pipe_ex_mem_elastic_if #(
    parameter int BITS = 32,
    parameter int AW   = 4,
    parameter int CW   = 3
);
    logic            validE;
    logic            readyE;
    logic [AW-1:0]   WA3E;
    logic [BITS-1:0] WriteDataE;
    logic [BITS-1:0] ALUResultE;
    logic [CW-1:0]   CtrlE;

    logic            validM;
    logic            readyM;
    logic [AW-1:0]   WA3M;
    logic [BITS-1:0] WriteDataM;
    logic [BITS-1:0] ALUResultM;
    logic [CW-1:0]   CtrlM;

    modport master (
        output validE, WA3E, WriteDataE, ALUResultE, CtrlE, readyM,
        input  readyE, validM, WA3M, WriteDataM, ALUResultM, CtrlM
    );

    modport slave (
        input  validE, WA3E, WriteDataE, ALUResultE, CtrlE, readyM,
        output readyE, validM, WA3M, WriteDataM, ALUResultM, CtrlM
    );
endinterface

// File: rtl/pipe_ex_mem_elastic.sv
// Elastic EX/MEM pipeline register: main register plus one skid slot, registered readyE, flush support.
// Optional macro PIPE_EX_MEM_STALLCNT_EN adds a saturating 32-bit stall_cnt output.
module pipe_ex_mem_elastic #(
    parameter int BITS = 32,
    parameter int AW   = 4,
    parameter int CW   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    pipe_ex_mem_elastic_if.slave   bus
`ifdef PIPE_EX_MEM_STALLCNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    typedef struct packed {
        logic [CW-1:0]   ctrl;
        logic [BITS-1:0] alu;
        logic [BITS-1:0] wd;
        logic [AW-1:0]   wa3;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   readyE_q;
    beat_t  main_q, main_d;
    beat_t  skid_q, skid_d;
    beat_t  ex_beat;
    logic   validM;
    logic   accept;
    logic   fire;

    always_comb begin
        ex_beat.ctrl = bus.CtrlE;
        ex_beat.alu  = bus.ALUResultE;
        ex_beat.wd   = bus.WriteDataE;
        ex_beat.wa3  = bus.WA3E;
    end

    assign validM = (state_q != EMPTY);
    assign accept = bus.validE & readyE_q & ~flush;
    assign fire   = validM & bus.readyM;

    // Flush wins over accept and fire: valids drop, data registers keep their contents.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = ex_beat;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        main_d = ex_beat;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = ex_beat;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            readyE_q <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            readyE_q <= (state_d != FULL);
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    // A bubble must not carry control side effects into MEM.
    assign bus.readyE     = readyE_q;
    assign bus.validM     = validM;
    assign bus.WA3M       = main_q.wa3;
    assign bus.WriteDataM = main_q.wd;
    assign bus.ALUResultM = main_q.alu;
    assign bus.CtrlM      = validM ? main_q.ctrl : '0;

`ifdef PIPE_EX_MEM_STALLCNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (validM && !bus.readyM && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ex_mem_elastic.sv
// Scoreboard bench for pipe_ex_mem_elastic: directed beats push expectations, a negedge monitor pops on fire.
// Exercises PIPE_EX_MEM_STALLCNT_EN checks when that macro is defined.
module tb_pipe_ex_mem_elastic;

    logic clk;
    logic rst;
    logic flush;
    int   tests;
    int   fails;
    logic [31:0] exp_q[$];

    pipe_ex_mem_elastic_if #(.BITS(32), .AW(4), .CW(3)) bus ();

`ifdef PIPE_EX_MEM_STALLCNT_EN
    logic [31:0] stall_cnt;
`endif

    pipe_ex_mem_elastic #(.BITS(32), .AW(4), .CW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef PIPE_EX_MEM_STALLCNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Side fields are derived from the ALU value so each beat is distinguishable in every field.
    function automatic logic [3:0] wa_of(input logic [31:0] v);
        return v[3:0] ^ 4'h5;
    endfunction

    function automatic logic [31:0] wd_of(input logic [31:0] v);
        return v ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [2:0] ctrl_of(input logic [31:0] v);
        return (v[2:0] ^ v[6:4]) | 3'b100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change just after a rising edge; the caller checks at the following falling edge.
    task automatic step(input logic v, input logic [31:0] val, input logic rm,
                        input logic fl, input logic rs, input logic expect_acc);
        @(posedge clk);
        #1;
        bus.validE     = v;
        bus.ALUResultE = val;
        bus.WA3E       = wa_of(val);
        bus.WriteDataE = wd_of(val);
        bus.CtrlE      = ctrl_of(val);
        bus.readyM     = rm;
        flush          = fl;
        rst            = rs;
        if (fl || rs) exp_q.delete();
        if (expect_acc) exp_q.push_back(val);
        @(negedge clk);
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && bus.validM && bus.readyM) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected none", bus.ALUResultM);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_alu",  bus.ALUResultM, e);
                    chk("mon_wa3",  32'(bus.WA3M), 32'(wa_of(e)));
                    chk("mon_wd",   bus.WriteDataM, wd_of(e));
                    chk("mon_ctrl", 32'(bus.CtrlM), 32'(ctrl_of(e)));
                end
            end
        end
    end

    initial begin : stim
        tests = 0;
        fails = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.validE = 1'b0;
        bus.readyM = 1'b0;
        bus.ALUResultE = '0;
        bus.WA3E = '0;
        bus.WriteDataE = '0;
        bus.CtrlE = '0;

        // Reset held for two edges
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_validM", 32'(bus.validM), 32'd0);
        chk("rst_readyE", 32'(bus.readyE), 32'd1);
        chk("rst_WA3M",   32'(bus.WA3M), 32'd0);
        chk("rst_ALUM",   bus.ALUResultM, 32'd0);
        chk("rst_CtrlM",  32'(bus.CtrlM), 32'd0);
`ifdef PIPE_EX_MEM_STALLCNT_EN
        chk("rst_stall", stall_cnt, 32'd0);
`endif

        // Full-throughput burst
        step(1, 32'h10, 1, 0, 0, 1);
        chk("burst_readyE0", 32'(bus.readyE), 32'd1);
        step(1, 32'h20, 1, 0, 0, 1);
        chk("burst_valid1", 32'(bus.validM), 32'd1);
        chk("burst_alu1", bus.ALUResultM, 32'h10);
        chk("burst_readyE1", 32'(bus.readyE), 32'd1);
        step(1, 32'h30, 1, 0, 0, 1);
        chk("burst_alu2", bus.ALUResultM, 32'h20);
        chk("burst_readyE2", 32'(bus.readyE), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        chk("burst_alu3", bus.ALUResultM, 32'h30);
        chk("burst_readyE3", 32'(bus.readyE), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        chk("bubble_valid", 32'(bus.validM), 32'd0);
        chk("bubble_ctrl", 32'(bus.CtrlM), 32'd0);
        chk("bubble_alu_hold", bus.ALUResultM, 32'h30);
        chk("bubble_wa3_hold", 32'(bus.WA3M), 32'(wa_of(32'h30)));

        // Back-pressure into the skid slot
        step(1, 32'h1, 0, 0, 0, 1);
        step(1, 32'h2, 0, 0, 0, 1);
        chk("bp_valid_one", 32'(bus.validM), 32'd1);
        chk("bp_readyE_one", 32'(bus.readyE), 32'd1);
        step(1, 32'h3, 0, 0, 0, 0);
        chk("bp_readyE_full", 32'(bus.readyE), 32'd0);
        chk("bp_alu_full", bus.ALUResultM, 32'h1);
        step(0, 0, 1, 0, 0, 0);
        chk("bp_readyE_still_full", 32'(bus.readyE), 32'd0);
        chk("bp_alu_stalled", bus.ALUResultM, 32'h1);
        step(1, 32'h3, 1, 0, 0, 1);
        chk("bp_readyE_drain", 32'(bus.readyE), 32'd1);
        chk("bp_alu_b", bus.ALUResultM, 32'h2);
        step(0, 0, 1, 0, 0, 0);
        chk("bp_alu_c", bus.ALUResultM, 32'h3);
        step(0, 0, 1, 0, 0, 0);
        chk("bp_empty", 32'(bus.validM), 32'd0);
        chk("bp_queue_drained", 32'(exp_q.size()), 32'd0);

        // Flush while FULL, with stall counting ahead of it
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef PIPE_EX_MEM_STALLCNT_EN
        chk("stall_cleared", stall_cnt, 32'd0);
`endif
        step(1, 32'hA, 0, 0, 0, 1);
        step(1, 32'hB, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("fl_full_readyE", 32'(bus.readyE), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h9, 1, 1, 0, 0);
`ifdef PIPE_EX_MEM_STALLCNT_EN
        chk("stall_five", stall_cnt, 32'd5);
`endif
        step(0, 0, 1, 0, 0, 0);
        chk("fl_validM", 32'(bus.validM), 32'd0);
        chk("fl_CtrlM", 32'(bus.CtrlM), 32'd0);
        chk("fl_readyE", 32'(bus.readyE), 32'd1);
        chk("fl_data_kept", bus.ALUResultM, 32'hA);
`ifdef PIPE_EX_MEM_STALLCNT_EN
        chk("stall_after_flush", stall_cnt, 32'd5);
`endif
        // Flush while EMPTY must still drop the offered beat
        step(1, 32'h55, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("fl_empty_validM", 32'(bus.validM), 32'd0);
        step(0, 0, 1, 0, 0, 0);
        chk("fl_empty_validM2", 32'(bus.validM), 32'd0);
        chk("fl_empty_data_kept", bus.ALUResultM, 32'hA);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef PIPE_EX_MEM_STALLCNT_EN
        chk("stall_rst", stall_cnt, 32'd0);
`endif

        // Reset and flush together mid-transfer: reset wins and clears data
        step(1, 32'h44, 0, 0, 0, 1);
        step(1, 32'h66, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("mid_full", 32'(bus.readyE), 32'd0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("mid_validM", 32'(bus.validM), 32'd0);
        chk("mid_readyE", 32'(bus.readyE), 32'd1);
        chk("mid_WA3M", 32'(bus.WA3M), 32'd0);
        chk("mid_ALUM", bus.ALUResultM, 32'd0);
        chk("mid_WDM", bus.WriteDataM, 32'd0);
        chk("mid_CtrlM", 32'(bus.CtrlM), 32'd0);
        step(1, 32'h77, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        chk("post_rst_alu", bus.ALUResultM, 32'h77);
        step(0, 0, 1, 0, 0, 0);
        chk("post_rst_empty", 32'(bus.validM), 32'd0);
        step(0, 0, 1, 0, 0, 0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
